pe_cfg_sequencer: RTL and testbench
===================================

Name: pe_cfg_sequencer

Overview:
Controller that sequences one pe_incha_single instance through a full layer pass. It converts a packed weight stream into the PE's weight write port protocol: all kernel bytes first, then all biases. It then gates input-window dispatch to the PE and counts accepted windows and returned results until the layer completes. It sits between the layer DMA/stream fabric and the PE.

Parameters:
IN_CHANNEL, 2, input channels per window (IN_CHANNEL*KERNEL_PTS <= 256)
OUT_CHANNEL, 4, output channels of the PE (<= 256)
KERNEL_PTS, 9, kernel points per channel (KERNEL_0*KERNEL_1)
NUM_WIN, 9, windows per layer pass (IN_WIDTH*IN_HEIGHT for stride 1, pad 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a pass; honoured only in IDLE
s_data  in  16  weight stream beat; kernel uses [7:0], bias uses full 16 bits signed
s_valid  in  1  stream beat valid
s_ready  out  1  stream beat accepted when s_valid & s_ready
weight_wr_data  out  16  to PE
weight_wr_addr  out  32  to PE
weight_wr_en  out  1  to PE, one cycle per accepted beat
win_valid  in  1  upstream window available (data routed directly to PE i_data)
win_ack  out  1  upstream window consumed (= pe_ack while in RUN)
pe_i_valid  out  1  to PE i_valid
pe_ack  in  1  from PE
pe_o_valid  in  1  from PE o_valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of pass
err  out  1  sticky; pe_o_valid seen outside RUN or beyond NUM_WIN results

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0; err cleared. Reset is asynchronous, so assertion mid-pass aborts immediately.
- FSM states: IDLE -> LOAD_K -> LOAD_B -> RUN -> DONE -> IDLE.
- IDLE: start=1 -> LOAD_K, clearing pos, och, win_cnt and res_cnt. start is ignored in all other states.
- LOAD_K: s_ready=1. Each accepted beat is registered into the write port on the next cycle:
  - weight_wr_en=1, weight_wr_addr={8'h00, och[7:0], pos[7:0], 8'h00}, weight_wr_data={8'h00, s_data[7:0]}.
  - pos increments from 0 to IN_CHANNEL*KERNEL_PTS-1, then wraps to 0 and och increments.
  - When the beat with och=OUT_CHANNEL-1 and pos=max is accepted -> LOAD_B with och=0.
- LOAD_B: s_ready=1. Each accepted beat produces weight_wr_addr={8'h01, och[7:0], 16'h0000}, weight_wr_data=s_data.
  - Last bias (och=OUT_CHANNEL-1) accepted -> RUN.
- Write latency is exactly 1 cycle from acceptance. Back-to-back beats give back-to-back writes. s_valid gaps give weight_wr_en=0 with addr/data held.
- s_ready=0 in IDLE, RUN and DONE. The last beat's write completes in the first RUN cycle; the PE write port needs no gap before dispatch.
- RUN dispatch:
  - pe_i_valid = win_valid & (win_cnt < NUM_WIN), registered-free (combinational from state/count).
  - win_ack = pe_ack & state==RUN. Each pe_ack increments win_cnt.
  - pe_i_valid stays high until pe_ack, then deasserts for at least the cycle after ack (matches the PE's single-window handshake).
- RUN results: each pe_o_valid increments res_cnt. pe_ack and pe_o_valid in the same cycle both count.
- RUN exit: win_cnt==NUM_WIN and res_cnt==NUM_WIN -> DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- err: pe_o_valid while not in RUN, or while res_cnt==NUM_WIN, sets err. Cleared only by rst. The extra result is not counted.
- Counter widths: pos and och are 8 bits; win_cnt and res_cnt are clog2(NUM_WIN+1) bits. Counters saturate, never wrap, in RUN.

Optional Feature:
PE_CFG_CHECKSUM_EN
- Defined: adds output cfg_checksum [15:0], the modulo-2^16 sum of every accepted s_data beat (kernel beats zero-extended from [7:0], biases full 16 bits).
  - Cleared on start and on rst.
  - Final value is valid from the first RUN cycle and held until the next start.
- Undefined: port and adder are absent; no other behaviour changes.

Test Plan:
- Reset mid-LOAD_K: after 10 beats assert rst -> s_ready, weight_wr_en, busy go 0 asynchronously; a new start reloads from och=0, pos=0.
- Full load with defaults: 72 kernel beats then biases 10, 20, -30, 40.
  - Kernel writes: first addr 32'h0000_0000, addr for och=1/pos=17 is 32'h0001_1100.
  - Bias writes: 32'h0100_0000 data 16'h000A; 32'h0102_0000 data 16'hFFE2.
  - Exactly 76 writes; then RUN.
- Stream stalls: s_valid toggling every other cycle -> weight_wr_en only follows accepted beats; addr sequence is identical to the unstalled load.
- RUN with PE model (ack 3 cycles after pe_i_valid, o_valid 5 cycles after ack) -> 9 acks, 9 results, done pulse exactly once, busy 0 the cycle after done.
- pe_ack and pe_o_valid coincident; start pulsed during RUN -> both counted, start ignored, pass still completes after 9 windows.
- Spurious pe_o_valid in IDLE -> err=1 and stays 1 until rst. With PE_CFG_CHECKSUM_EN, the default load gives cfg_checksum = 18*(1+2+3+4)+40 = 16'h00DC.

Source files
------------

// File: rtl/pe_cfg_sequencer.sv
// Layer-pass controller for one PE: streams kernel bytes then biases into the PE weight port,
// then gates window dispatch and counts acks/results. Optional checksum: PE_CFG_CHECKSUM_EN.
module pe_cfg_sequencer #(
  parameter int unsigned IN_CHANNEL  = 2,
  parameter int unsigned OUT_CHANNEL = 4,
  parameter int unsigned KERNEL_PTS  = 9,
  parameter int unsigned NUM_WIN     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  input  logic        win_valid,
  output logic        win_ack,
  output logic        pe_i_valid,
  input  logic        pe_ack,
  input  logic        pe_o_valid,
  output logic        busy,
  output logic        done,
`ifdef PE_CFG_CHECKSUM_EN
  output logic [15:0] cfg_checksum,
`endif
  output logic        err
);

  localparam int unsigned CntW   = $clog2(NUM_WIN + 1);
  localparam logic [7:0]  PosMax = 8'(IN_CHANNEL * KERNEL_PTS - 1);
  localparam logic [7:0]  OchMax = 8'(OUT_CHANNEL - 1);
  localparam logic [CntW-1:0] WinMax = CntW'(NUM_WIN);

  typedef enum logic [2:0] {StIdle, StLoadK, StLoadB, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      pos_q, pos_d, och_q, och_d;
  logic [CntW-1:0] win_cnt_q, win_cnt_d, res_cnt_q, res_cnt_d;
  logic            err_q, err_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            ack_hold_q, ack_hold_d;
  logic            accept, run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      och_q      <= '0;
      win_cnt_q  <= '0;
      res_cnt_q  <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ack_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      och_q      <= och_d;
      win_cnt_q  <= win_cnt_d;
      res_cnt_q  <= res_cnt_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ack_hold_q <= ack_hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    och_d      = och_q;
    win_cnt_d  = win_cnt_q;
    res_cnt_d  = res_cnt_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ack_hold_d = 1'b0;

    run     = (state_q == StRun);
    s_ready = (state_q == StLoadK) || (state_q == StLoadB);
    accept  = s_valid & s_ready;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    win_ack = run & pe_ack;
    // One idle cycle after each ack mirrors the PE's single-window handshake.
    pe_i_valid = run & win_valid & (win_cnt_q < WinMax) & ~ack_hold_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoadK;
          pos_d     = '0;
          och_d     = '0;
          win_cnt_d = '0;
          res_cnt_d = '0;
        end
      end
      StLoadK: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {8'h00, och_q, pos_q, 8'h00};
          wr_data_d = {8'h00, s_data[7:0]};
          if (pos_q == PosMax) begin
            pos_d = '0;
            if (och_q == OchMax) begin
              och_d   = '0;
              state_d = StLoadB;
            end else begin
              och_d = och_q + 8'd1;
            end
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end
      end
      StLoadB: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {8'h01, och_q, 16'h0000};
          wr_data_d = s_data;
          if (och_q == OchMax) begin
            och_d   = '0;
            state_d = StRun;
          end else begin
            och_d = och_q + 8'd1;
          end
        end
      end
      StRun: begin
        if (pe_ack) begin
          ack_hold_d = 1'b1;
          if (win_cnt_q < WinMax) win_cnt_d = win_cnt_q + 1'b1;
        end
        if (pe_o_valid && (res_cnt_q < WinMax)) res_cnt_d = res_cnt_q + 1'b1;
        if ((win_cnt_q == WinMax) && (res_cnt_q == WinMax)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (pe_o_valid && (!run || (res_cnt_q == WinMax))) err_d = 1'b1;
  end

  assign weight_wr_en   = wr_en_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_data = wr_data_q;
  assign err            = err_q;

`ifdef PE_CFG_CHECKSUM_EN
  logic [15:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if ((state_q == StIdle) && start) begin
      cks_d = '0;
    end else if (accept) begin
      cks_d = cks_q + ((state_q == StLoadK) ? {8'h00, s_data[7:0]} : s_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end

  assign cfg_checksum = cks_q;
`endif

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Directed self-checking bench for pe_cfg_sequencer with an inline PE handshake model.
module tb_pe_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, weight_wr_en;
  logic [15:0] s_data, weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        win_valid, win_ack, pe_i_valid, pe_ack, pe_o_valid, busy, done, err;
`ifdef PE_CFG_CHECKSUM_EN
  logic [15:0] cfg_checksum;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] bias [4] = '{16'd10, 16'd20, 16'hFFE2, 16'd40};

  always #5 clk = ~clk;

  pe_cfg_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .weight_wr_data (weight_wr_data),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_en   (weight_wr_en),
    .win_valid      (win_valid),
    .win_ack        (win_ack),
    .pe_i_valid     (pe_i_valid),
    .pe_ack         (pe_ack),
    .pe_o_valid     (pe_o_valid),
    .busy           (busy),
    .done           (done),
`ifdef PE_CFG_CHECKSUM_EN
    .cfg_checksum   (cfg_checksum),
`endif
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Kernel beats carry junk in the upper byte to exercise the zero-extension.
  function automatic logic [15:0] beat(input int b);
    if (b < 72) return {8'hA5, 8'(b / 18 + 1)};
    return bias[b - 72];
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    if (i < 72) return {8'h00, 8'(i / 18), 8'(i % 18), 8'h00};
    return {8'h01, 8'(i - 72), 16'h0000};
  endfunction

  function automatic logic [15:0] exp_data(input int i);
    if (i < 72) return {8'h00, 8'(i / 18 + 1)};
    return bias[i - 72];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_load(input bit stall);
    int  b   = 0;
    int  cyc = 0;
    bit  acc;
    while (b < 76 && cyc < 400) begin
      s_valid = stall ? (cyc % 2 == 0) : 1'b1;
      s_data  = s_valid ? beat(b) : 16'hDEAD;
      acc     = s_valid && s_ready;
      tick();
      chk("wr_en_follows_accept", 64'(weight_wr_en), 64'(acc));
      if (acc) begin
        chk("wr_addr", 64'(weight_wr_addr), 64'(exp_addr(b)));
        chk("wr_data", 64'(weight_wr_data), 64'(exp_data(b)));
        if (b == 0)  chk("first_addr", 64'(weight_wr_addr), 64'h0000_0000);
        if (b == 35) chk("och1_pos17_addr", 64'(weight_wr_addr), 64'h0001_1100);
        if (b == 72) chk("bias0_addr", 64'({weight_wr_addr, weight_wr_data[7:0]}),
                         64'h01_0000_000A);
        if (b == 74) chk("bias2_write", 64'({weight_wr_addr[31:16], weight_wr_data}),
                         64'h0102_FFE2);
        b++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    chk("write_count", 64'(b), 64'd76);
    chk("run_s_ready", 64'(s_ready), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    tick();
    chk("no_write_after_load", 64'(weight_wr_en), 64'd0);
  endtask

  task automatic run_pass(input int ack_lat, input int res_lat, input bit start_mid);
    int          acks = 0, res = 0, dones = 0, vcnt = 0, cyc = 0;
    bit          seen_done = 0, prev_ack = 0, ack;
    logic [15:0] pend = '0;
    win_valid = 1'b1;
    while (cyc < 500) begin
      if (seen_done) begin
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_single_cycle", 64'(done), 64'd0);
        break;
      end
      pe_o_valid = pend[res_lat-1];
      if (prev_ack) chk("holdoff_after_ack", 64'(pe_i_valid), 64'd0);
      ack = 1'b0;
      if (pe_i_valid) begin
        vcnt++;
        if (vcnt == ack_lat) begin
          ack  = 1'b1;
          vcnt = 0;
        end
      end else begin
        vcnt = 0;
      end
      pe_ack = ack;
      start  = start_mid && (cyc == 20);
      #1;
      if (win_ack) acks++;
      if (pe_o_valid) res++;
      if (done) begin
        dones++;
        seen_done = 1;
      end
      pend     = {pend[14:0], ack};
      prev_ack = ack;
      @(posedge clk);
      #1;
      cyc++;
    end
    pe_ack = 0; pe_o_valid = 0; win_valid = 0; start = 0;
    chk("pass_finished", 64'(seen_done), 64'd1);
    chk("ack_count", 64'(acks), 64'd9);
    chk("result_count", 64'(res), 64'd9);
    chk("done_pulses", 64'(dones), 64'd1);
    chk("err_clean_pass", 64'(err), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 0; s_valid = 0; s_data = '0;
    win_valid = 0; pe_ack = 0; pe_o_valid = 0;
    tick(); tick();
    chk("reset_outputs",
        64'({s_ready, weight_wr_en, win_ack, pe_i_valid, busy, done, err}), 64'd0);
    chk("reset_addr", 64'(weight_wr_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Abort a load part way with an asynchronous reset.
    pulse_start();
    chk("loadk_s_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = beat(i);
      tick();
    end
    chk("mid_load_wr_en", 64'(weight_wr_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst", 64'({s_ready, weight_wr_en, busy}), 64'd0);
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Full unstalled load and a pass without coincident ack/result.
    pulse_start();
    do_load(1'b0);
`ifdef PE_CFG_CHECKSUM_EN
    chk("checksum", 64'(cfg_checksum), 64'h00DC);
`endif
    run_pass(3, 5, 1'b0);

    // Stalled stream, coincident ack/result, start ignored during RUN.
    pulse_start();
    do_load(1'b1);
`ifdef PE_CFG_CHECKSUM_EN
    chk("checksum_reloaded", 64'(cfg_checksum), 64'h00DC);
`endif
    run_pass(1, 4, 1'b1);
    chk("idle_after_pass", 64'(busy), 64'd0);

    // Spurious result in IDLE.
    pe_o_valid = 1'b1;
    tick();
    pe_o_valid = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    tick(); tick(); tick();
    chk("err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    #1;
    chk("err_cleared", 64'(err), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
